// File: rtl/master_bus_requester.sv
// Master-side bus requester: raises request, serially sends the slave ID LSB first after grant, then holds the bus.
// Optional grant-wait timeout is enabled by defining REQ_TIMEOUT_EN.
module master_bus_requester #(
  parameter int SLAVE_BITS = 2,
  parameter int TIMEOUT    = 200,
  parameter int TO_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SLAVE_BITS-1:0] slave_id,
  input  logic                  txn_done,
  input  logic                  grant,
  output logic                  request,
  output logic                  slave_sel,
  output logic                  bus_owned,
  output logic                  ready,
  output logic                  preempted,
  output logic                  timeout
);

  localparam int IDX_W = (SLAVE_BITS > 1) ? $clog2(SLAVE_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLAVE_BITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SEL  = 2'd2;
  localparam logic [1:0] OWN  = 2'd3;

  logic [1:0]            state;
  logic [SLAVE_BITS-1:0] id;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      next_idx;

  assign next_idx = idx + 1'b1;

`ifdef REQ_TIMEOUT_EN
  logic [TO_W-1:0] wait_cnt;
  logic            timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      id        <= '0;
      idx       <= '0;
      request   <= 1'b0;
      slave_sel <= 1'b0;
      bus_owned <= 1'b0;
      ready     <= 1'b1;
      preempted <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      preempted <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            id        <= slave_id;
            idx       <= '0;
            state     <= REQ;
            request   <= 1'b1;
            ready     <= 1'b0;
            slave_sel <= slave_id[0];
`ifdef REQ_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end

        // REQ and SEL advance identically on grant; the first grant cycle carries bit 0.
        REQ, SEL: begin
          if (grant) begin
            if (idx == LAST_IDX) begin
              state     <= OWN;
              bus_owned <= 1'b1;
              slave_sel <= 1'b0;
            end else begin
              state     <= SEL;
              idx       <= next_idx;
              slave_sel <= id[next_idx];
            end
          end else if (state == SEL) begin
            preempted <= 1'b1;
            idx       <= '0;
            slave_sel <= id[0];
            state     <= REQ;
`ifdef REQ_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else begin
`ifdef REQ_TIMEOUT_EN
            if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              request   <= 1'b0;
              ready     <= 1'b1;
              slave_sel <= 1'b0;
              state     <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
`endif
          end
        end

        // Completion wins over a simultaneous grant loss.
        OWN: begin
          if (txn_done) begin
            state     <= IDLE;
            request   <= 1'b0;
            bus_owned <= 1'b0;
            ready     <= 1'b1;
          end else if (!grant) begin
            preempted <= 1'b1;
            bus_owned <= 1'b0;
            idx       <= '0;
            slave_sel <= id[0];
            state     <= REQ;
`ifdef REQ_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_bus_requester.sv
// Randomized + directed bench for master_bus_requester against a grant-cycle-counting reference model.
module tb_master_bus_requester;

  localparam int SB = 2;
`ifdef REQ_TIMEOUT_EN
  localparam int  TB_TIMEOUT = 5;
  localparam bit  timeoutEn  = 1'b1;
`else
  localparam int  TB_TIMEOUT = 200;
  localparam bit  timeoutEn  = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [SB-1:0] slave_id;
  logic          txn_done;
  logic          grant;
  logic          request, slave_sel, bus_owned, ready, preempted, timeout;

  int checkCount = 0;
  int failCount  = 0;
  string phase = "reset";

  // Reference model: a transaction is active from start until done/timeout;
  // grantCycles counts consecutive grant-high cycles of the current attempt.
  bit          mActive;
  logic [SB-1:0] mId;
  int          mGrantCycles;
  int          mWait;
  bit          mPreempt;
  bit          mTimeout;

  master_bus_requester #(
    .SLAVE_BITS(SB),
    .TIMEOUT(TB_TIMEOUT),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .slave_id(slave_id),
    .txn_done(txn_done),
    .grant(grant),
    .request(request),
    .slave_sel(slave_sel),
    .bus_owned(bus_owned),
    .ready(ready),
    .preempted(preempted),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got {req,sel,own,rdy,pre,to}=%b expected=%b", tag, $time, observed, expected);
    end
  endtask

  task automatic loseGrant();
    mPreempt     = 1'b1;
    mGrantCycles = 0;
    mWait        = 0;
  endtask

  task automatic modelStep();
    mPreempt = 1'b0;
    mTimeout = 1'b0;
    if (!rst) begin
      mActive = 1'b0; mId = '0; mGrantCycles = 0; mWait = 0;
    end else if (!mActive) begin
      if (start) begin
        mActive = 1'b1; mId = slave_id; mGrantCycles = 0; mWait = 0;
      end
    end else if (mGrantCycles >= SB) begin
      if (txn_done) mActive = 1'b0;
      else if (!grant) loseGrant();
    end else if (grant) begin
      mGrantCycles++;
    end else if (mGrantCycles > 0) begin
      loseGrant();
    end else begin
      mWait++;
      if (timeoutEn && mWait == TB_TIMEOUT) begin
        mTimeout = 1'b1;
        mActive  = 1'b0;
      end
    end
  endtask

  function automatic logic [5:0] modelExpected();
    logic owned, sel;
    owned = mActive && (mGrantCycles >= SB);
    sel   = (mActive && !owned) ? mId[mGrantCycles] : 1'b0;
    return {mActive, sel, owned, !mActive, mPreempt, mTimeout};
  endfunction

  task automatic applyStimulus(input bit r, input bit s, input logic [SB-1:0] id, input bit d, input bit g);
    rst = r; start = s; slave_id = id; txn_done = d; grant = g;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(phase, {request, slave_sel, bus_owned, ready, preempted, timeout}, modelExpected());
    @(negedge clk);
  endtask

  task automatic repeatStimulus(input int n, input bit r, input bit s, input logic [SB-1:0] id, input bit d, input bit g);
    for (int i = 0; i < n; i++) applyStimulus(r, s, id, d, g);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; slave_id = '0; txn_done = 1'b0; grant = 1'b0;
    mActive = 1'b0; mId = '0; mGrantCycles = 0; mWait = 0; mPreempt = 1'b0; mTimeout = 1'b0;
    @(negedge clk);

    phase = "reset";
    repeat (3) applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    checkOutput("reset_const", {request, slave_sel, bus_owned, ready, preempted, timeout}, 6'b000100);

    phase = "idle_grant";
    repeatStimulus(2, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);

    phase = "basic";
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    repeatStimulus(2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    repeatStimulus(4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);

    phase = "preempt";
    repeatStimulus(3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    repeatStimulus(4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);

    phase = "collision";
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    repeatStimulus(3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    repeatStimulus(3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

    phase = "reset_mid_own";
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    repeatStimulus(3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

    phase = "grant_wait";
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    repeatStimulus(300, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
`ifndef REQ_TIMEOUT_EN
    checkOutput("still_requesting", {5'b0, request}, 6'd1);
`endif
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(63) != 0),
                    ($urandom_range(3) == 0),
                    SB'($urandom),
                    ($urandom_range(7) == 0),
                    ($urandom_range(3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
